// File: rtl/instr_dispatcher_pkg.sv
// Shared definitions for the dispatcher and the downstream issue queues:
// RISC-V major opcodes and the execution-unit select encoding.
package instr_dispatcher_pkg;

  typedef enum logic [1:0] {
    UNIT_INTALU = 2'd0,
    UNIT_FPALU  = 2'd1,
    UNIT_AGU    = 2'd2
  } unit_sel_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_MADD     = 7'b1000011;
  localparam logic [6:0] OPC_MSUB     = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB    = 7'b1001011;
  localparam logic [6:0] OPC_NMADD    = 7'b1001111;

  // Memory ops go to the AGU, FP arithmetic to the FPALU, everything else
  // (including illegal encodings) to the INTALU, which raises the trap.
  function automatic unit_sel_e classify_opcode(input logic [6:0] opc);
    unit_sel_e unit;
    unit = UNIT_INTALU;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_LOAD_FP, OPC_STORE_FP: unit = UNIT_AGU;
      OPC_OP_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: unit = UNIT_FPALU;
      default: unit = UNIT_INTALU;
    endcase
    return unit;
  endfunction

endpackage

// File: rtl/instr_dispatcher_sync_fifo.sv
// Synchronous FIFO used as the instruction fetch queue. DEPTH must be a power
// of two so the pointers wrap naturally; the head word is presented combinationally.
module sync_fifo
  import instr_dispatcher_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en_s;
  logic             pop_en_s;

  assign empty_o   = (count_q == {CW{1'b0}});
  assign full_o    = (count_q == DEPTH_C);
  assign pop_en_s  = pop_i && !empty_o;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push_en_s = push_i && (!full_o || pop_en_s);
  assign rdata_o   = empty_o ? {WIDTH{1'b0}} : mem_q[head_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_en_s) begin
      head_d = head_q + 1'b1;
    end else begin
      head_d = head_q;
    end
    if (push_en_s) begin
      tail_d = tail_q + 1'b1;
    end else begin
      tail_d = tail_q;
    end
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is left uninitialised; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en_s && resetn) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_dispatcher.sv
// In-order instruction dispatcher: classifies the IFQ head by opcode and pushes
// it into the INTALU, FPALU or AGU issue queue when that queue has room.
module instr_dispatcher
  import instr_dispatcher_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int IFQ_DEPTH = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enq_ifq,
  input  logic            deq_ifq,
  input  logic [XLEN-1:0] data_in_ifq,
  input  logic            full_intalu,
  input  logic            full_fpalu,
  input  logic            full_agu,
  output logic            full_ifq,
  output logic            empty_ifq,
  output logic            enq_intalu,
  output logic            enq_fpalu,
  output logic            enq_agu,
  output logic [XLEN-1:0] intalu_data_i,
  output logic [XLEN-1:0] fpalu_data_i,
  output logic [XLEN-1:0] agu_data_i
);

  logic [XLEN-1:0] head_s;
  unit_sel_e       unit_s;
  logic            tgt_full_s;
  logic            dispatch_s;

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (IFQ_DEPTH)
  ) u_ifq (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (enq_ifq),
    .pop_i   (dispatch_s),
    .wdata_i (data_in_ifq),
    .rdata_o (head_s),
    .full_o  (full_ifq),
    .empty_o (empty_ifq)
  );

  // Target selection and dispatch strobes; a stalled head blocks younger entries.
  always_comb begin
    unit_s     = classify_opcode(head_s[6:0]);
    tgt_full_s = full_intalu;
    case (unit_s)
      UNIT_FPALU:  tgt_full_s = full_fpalu;
      UNIT_AGU:    tgt_full_s = full_agu;
      UNIT_INTALU: tgt_full_s = full_intalu;
      default:     tgt_full_s = full_intalu;
    endcase
    dispatch_s = deq_ifq && !empty_ifq && !tgt_full_s;
    enq_intalu = dispatch_s && (unit_s == UNIT_INTALU);
    enq_fpalu  = dispatch_s && (unit_s == UNIT_FPALU);
    enq_agu    = dispatch_s && (unit_s == UNIT_AGU);
  end

  assign intalu_data_i = head_s;
  assign fpalu_data_i  = head_s;
  assign agu_data_i    = head_s;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed and randomised checks of instr_dispatcher against a queue-based
// reference model of the IFQ and an independent opcode-to-unit table.
module tb_instr_dispatcher;

  localparam int XLEN      = 32;
  localparam int IFQ_DEPTH = 8;

  logic            clk;
  logic            resetn;
  logic            enq_ifq, deq_ifq;
  logic [XLEN-1:0] data_in_ifq;
  logic            full_intalu, full_fpalu, full_agu;
  logic            full_ifq, empty_ifq;
  logic            enq_intalu, enq_fpalu, enq_agu;
  logic [XLEN-1:0] intalu_data_i, fpalu_data_i, agu_data_i;

  int checks   = 0;
  int failures = 0;
  logic [XLEN-1:0] model_q[$];

  instr_dispatcher #(.XLEN(XLEN), .IFQ_DEPTH(IFQ_DEPTH)) dut (
    .clk(clk), .resetn(resetn), .enq_ifq(enq_ifq), .deq_ifq(deq_ifq),
    .data_in_ifq(data_in_ifq), .full_intalu(full_intalu), .full_fpalu(full_fpalu),
    .full_agu(full_agu), .full_ifq(full_ifq), .empty_ifq(empty_ifq),
    .enq_intalu(enq_intalu), .enq_fpalu(enq_fpalu), .enq_agu(enq_agu),
    .intalu_data_i(intalu_data_i), .fpalu_data_i(fpalu_data_i), .agu_data_i(agu_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 = INTALU, 1 = FPALU, 2 = AGU
  function automatic logic [1:0] ref_unit(input logic [6:0] opc);
    case (opc)
      7'h03, 7'h23, 7'h07, 7'h27:        return 2'd2;
      7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: return 2'd1;
      default:                           return 2'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs vs model, advance model at the edge.
  task automatic step(input logic e, input logic [31:0] d, input logic dq,
                      input logic fi, input logic ff, input logic fa);
    int n;
    logic [1:0] u;
    logic tf, disp;
    logic [31:0] hd;
    enq_ifq = e; data_in_ifq = d; deq_ifq = dq;
    full_intalu = fi; full_fpalu = ff; full_agu = fa;
    #1;
    n  = model_q.size();
    hd = (n == 0) ? 32'h0 : model_q[0];
    u  = ref_unit(hd[6:0]);
    tf = (u == 2'd2) ? fa : ((u == 2'd1) ? ff : fi);
    disp = dq && (n != 0) && !tf;
    chk("empty_ifq", {31'd0, empty_ifq}, {31'd0, n == 0});
    chk("full_ifq", {31'd0, full_ifq}, {31'd0, n == IFQ_DEPTH});
    chk("enq_intalu", {31'd0, enq_intalu}, {31'd0, disp && u == 2'd0});
    chk("enq_fpalu", {31'd0, enq_fpalu}, {31'd0, disp && u == 2'd1});
    chk("enq_agu", {31'd0, enq_agu}, {31'd0, disp && u == 2'd2});
    chk("intalu_data", intalu_data_i, hd);
    chk("fpalu_data", fpalu_data_i, hd);
    chk("agu_data", agu_data_i, hd);
    @(posedge clk);
    if (disp) void'(model_q.pop_front());
    if (e && (n < IFQ_DEPTH || disp)) model_q.push_back(d);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset edge with push and dispatch requested at the same time.
  task automatic do_reset();
    resetn = 1'b0; enq_ifq = 1'b1; deq_ifq = 1'b1; data_in_ifq = 32'hDEAD_BEEF;
    full_intalu = 1'b0; full_fpalu = 1'b0; full_agu = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_q.delete();
  endtask

  logic [6:0] opcs [12] = '{7'h03, 7'h23, 7'h07, 7'h27, 7'h53, 7'h43,
                            7'h47, 7'h4B, 7'h4F, 7'h13, 7'h33, 7'h7F};

  initial begin
    logic [31:0] r;
    resetn = 1'b0; enq_ifq = 1'b0; deq_ifq = 1'b0; data_in_ifq = 32'h0;
    full_intalu = 1'b0; full_fpalu = 1'b0; full_agu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();

    // addi then dispatch to INTALU
    push(32'h0050_0093);
    pop();
    idle();

    // lw then fadd.s, in order to AGU then FPALU
    push(32'h0000_A103);
    push(32'h0020_81D3);
    pop();
    pop();
    idle();

    // fill with 9 words; 9th dropped; drain 8
    for (int i = 1; i <= 9; i++) push(32'h0000_0093 | (i << 20));
    idle();
    for (int i = 0; i < 8; i++) pop();
    idle();

    // AGU back-pressure stalls lw at head
    push(32'h0000_A103);
    push(32'h0050_0093);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    pop();
    pop();
    idle();

    // full queue with simultaneous push and dispatch, then mixed traffic
    for (int i = 0; i < 8; i++) push(32'h1000_0013 + (i << 20));
    step(1'b1, 32'h7770_0013, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      step(1'($urandom_range(0, 1)), {r[31:7], opcs[$urandom_range(0, 11)]},
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 10; i++) pop();
    idle();

    // reset mid-operation discards queued work
    for (int i = 0; i < 5; i++) push(32'h0000_2003 + (i << 20));
    do_reset();
    idle();
    push(32'h0020_81D3);
    pop();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
INSTR_DISPATCHER -- requirements
Module: instr_dispatcher

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, instruction/data width; IFQ_DEPTH, default 8, instruction-queue entries (power of two).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 enq_ifq  input  1  push data_in_ifq into the instruction fetch queue (IFQ).
REQ-005 deq_ifq  input  1  request dispatch of the IFQ head this cycle.
REQ-006 data_in_ifq  input  XLEN  fetched RISC-V instruction word.
REQ-007 full_intalu / full_fpalu / full_agu  input  1 each  downstream issue queue cannot accept.
REQ-008 full_ifq  output  1  IFQ holds IFQ_DEPTH entries.
REQ-009 empty_ifq  output  1  IFQ holds zero entries.
REQ-010 enq_intalu / enq_fpalu / enq_agu  output  1 each  one-hot push strobe to target issue queue.
REQ-011 intalu_data_i / fpalu_data_i / agu_data_i  output  XLEN each  instruction presented to each issue queue.

Function
REQ-012 IFQ SHALL be a FIFO of IFQ_DEPTH words with head/tail pointers wrapping modulo IFQ_DEPTH and an occupancy count 0..IFQ_DEPTH.
REQ-013 Push SHALL occur when enq_ifq=1 and (full_ifq=0 or a dispatch happens the same cycle); push while full without dispatch SHALL be dropped, state unchanged.
REQ-014 Head opcode bits[6:0] SHALL select the target: 0000011, 0100011, 0000111, 0100111 -> AGU; 1010011, 1000011, 1000111, 1001011, 1001111 -> FPALU; every other opcode (incl. illegal) -> INTALU.
REQ-015 Dispatch SHALL occur when deq_ifq=1, empty_ifq=0 and the selected target's full input is 0.
REQ-016 On dispatch, the selected enq_* SHALL be 1 combinationally in the same cycle and the head entry SHALL be popped at that clock edge; at most one enq_* high per cycle.
REQ-017 If the target is full, or the IFQ is empty, all enq_* SHALL be 0 and the head SHALL be retained (stall, in-order, no bypass of younger entries).
REQ-018 All three *_data_i outputs SHALL carry the current head word whenever empty_ifq=0, and all-zero when empty.
REQ-019 A word pushed at edge N SHALL be dispatchable no earlier than the cycle following edge N (no same-cycle push-to-dispatch bypass).
REQ-020 Simultaneous push and dispatch SHALL leave occupancy unchanged, including when full.
REQ-021 full_ifq and empty_ifq SHALL be decoded from registered occupancy only.

Reset
REQ-022 resetn=0 at a rising edge SHALL clear pointers and count: empty_ifq=1, full_ifq=0, all enq_*=0, all *_data_i=0; reset has priority over concurrent push/dispatch.
REQ-023 Storage contents need not be cleared; reset mid-operation SHALL discard all queued instructions.

Structure
REQ-024 Opcode constants and a 2-bit unit-select enum (INTALU, FPALU, AGU) SHALL live in a shared package used by dispatcher and downstream issue queues.
REQ-025 The IFQ SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH); classification and dispatch logic stays in instr_dispatcher.

Verification
REQ-026 Push 0x00500093 (addi), deq_ifq=1 next cycle, all fulls 0 -> enq_intalu=1, intalu_data_i=0x00500093, empty_ifq=1 after edge.
REQ-027 Push 0x0000A103 (lw) then 0x002081D3 (fadd.s); dispatch both -> enq_agu then enq_fpalu on consecutive cycles, order preserved.
REQ-028 Push 9 words without dispatch -> full_ifq=1 after 8th; 9th dropped; eight dispatches return words 1..8 in order, then empty_ifq=1.
REQ-029 lw at head, full_agu=1, deq_ifq=1 for 3 cycles -> no enq_*, head unchanged; full_agu=0 -> enq_agu=1 next cycle.
REQ-030 IFQ full, enq_ifq=1 and dispatch same cycle -> count stays 8, new word at tail; pointers wrap correctly over 20 mixed operations.
REQ-031 Load 5 entries, resetn=0 for one edge -> empty_ifq=1, enq_*=0, subsequent push/dispatch behaves as from power-up.
